// File: rtl/avalon_led_responder.sv
// Avalon-MM register file driving four user LEDs with per-LED 8-bit PWM
// brightness and a programmable blink phase; fixed one-cycle read latency.
module avalon_led_responder #(
  parameter int          CLK_HZ   = 50_000_000,
  parameter logic [31:0] ID_VALUE = 32'h1ED0_0001
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [3:0]  led_out
);

  localparam logic [25:0] PERIOD_RST = 26'(CLK_HZ / 2);

  logic [1:0]  ctrl;
  logic [3:0]  led_val;
  logic [31:0] duty;
  logic [25:0] period;
  logic [7:0]  pwm_cnt;
  logic [25:0] blink_cnt;
  logic        phase;
  logic [25:0] period_eff;
  logic        period_hit;
  logic [3:0]  pwm_lit;
  logic [3:0]  led_next;
  logic [31:0] rd_mux;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl    <= 2'b00;
      led_val <= 4'h0;
      duty    <= 32'hFFFF_FFFF;
      period  <= PERIOD_RST;
    end else if (avs_write) begin
      case (avs_address)
        3'd0: if (avs_byteenable[0]) ctrl <= avs_writedata[1:0];
        3'd1: if (avs_byteenable[0]) led_val <= avs_writedata[3:0];
        3'd2: duty <= byte_merge(duty, avs_writedata, avs_byteenable);
        3'd3: begin
          if (avs_byteenable[0]) period[7:0]   <= avs_writedata[7:0];
          if (avs_byteenable[1]) period[15:8]  <= avs_writedata[15:8];
          if (avs_byteenable[2]) period[23:16] <= avs_writedata[23:16];
          if (avs_byteenable[3]) period[25:24] <= avs_writedata[25:24];
        end
        default: ;
      endcase
    end
  end

  // A zero period behaves as one so the phase toggles every cycle.
  assign period_eff = (period == 26'd0) ? 26'd1 : period;
  assign period_hit = avs_write && (avs_address == 3'd3);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_cnt   <= 8'd0;
      blink_cnt <= 26'd0;
      phase     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (period_hit) begin
        blink_cnt <= 26'd0;
      end else if (blink_cnt >= period_eff - 26'd1) begin
        blink_cnt <= 26'd0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 26'd1;
      end
    end
  end

  always_comb begin
    pwm_lit = 4'h0;
    for (int i = 0; i < 4; i++)
      pwm_lit[i] = (pwm_cnt < duty[8*i +: 8]) || (duty[8*i +: 8] == 8'hFF);
    led_next = {4{ctrl[0]}} & led_val & pwm_lit & {4{ctrl[1] ? phase : 1'b1}};
  end

  always_comb begin
    rd_mux = 32'h0;
    case (avs_address)
      3'd0: rd_mux = {30'h0, ctrl};
      3'd1: rd_mux = {28'h0, led_val};
      3'd2: rd_mux = duty;
      3'd3: rd_mux = {6'h0, period};
      3'd4: rd_mux = {23'h0, phase, 4'h0, led_out};
      3'd5: rd_mux = ID_VALUE;
      default: rd_mux = 32'h0;
    endcase
  end

  // Output stage: LED drive and read response, one cycle behind the access.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led_out           <= 4'h0;
      avs_readdata      <= 32'h0;
      avs_readdatavalid <= 1'b0;
    end else begin
      led_out <= led_next;
      if (avs_read && !avs_write) begin
        avs_readdata      <= rd_mux;
        avs_readdatavalid <= 1'b1;
      end else begin
        avs_readdatavalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avalon_led_responder.sv
// Scoreboard bench for avalon_led_responder: reads push expected data and
// due cycle; an independent monitor pops and compares on every response.
module tb_avalon_led_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [3:0]  led_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  avalon_led_responder dut (
    .clk_clk           (clk),
    .reset_reset_n     (reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .led_out           (led_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (avs_readdatavalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_readdatavalid got data %h at cycle %0d required no response",
                   avs_readdata, cyc);
        end else begin
          e = sb.pop_front();
          if (avs_readdata !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL %s got %h at cycle %0d required %h at cycle %0d",
                     e.name, avs_readdata, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_byteenable = 4'h0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    avs_address = a; avs_read = 1'b1;
    sb.push_back('{n, e, cyc + 1});
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic pwm_count(input int led, input int exp_on);
    int on;
    on = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_out[led]) on++;
    end
    chk($sformatf("pwm_on_led%0d", led), on, exp_on);
  endtask

  task automatic blink_runs(input int exp_len, input int nsamp);
    logic prev;
    int   last_t;
    int   edges;
    last_t = -1;
    edges  = 0;
    @(negedge clk);
    prev = led_out[0];
    for (int i = 1; i < nsamp; i++) begin
      @(negedge clk);
      if (led_out[0] != prev) begin
        if (last_t >= 0) chk($sformatf("blink_run_len_p%0d", exp_len), i - last_t, exp_len);
        last_t = i;
        edges++;
      end
      prev = led_out[0];
    end
    checks++;
    if (edges < 3) begin
      errors++;
      $display("FAIL blink_edges got %0d required at least 3", edges);
    end
  endtask

  initial begin
    // Power-up reset.
    idle(3);
    chk("rst_led_out", {28'h0, led_out}, 32'h0);
    chk("rst_readdatavalid", {31'h0, avs_readdatavalid}, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    idle(2);

    rd(3'd5, 32'h1ED0_0001, "id");
    rd(3'd3, 32'd25_000_000, "period_rst");
    rd(3'd2, 32'hFFFF_FFFF, "duty_rst");
    rd(3'd0, 32'h0, "ctrl_rst");
    rd(3'd1, 32'h0, "ledval_rst");
    idle(2);

    // Byte lanes.
    wr(3'd2, 32'h0000_0000, 4'b0010);
    rd(3'd2, 32'hFFFF_00FF, "duty_byteenable");
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    rd(3'd0, 32'h3, "ctrl_width");
    wr(3'd0, 32'h1, 4'hF);

    // Static drive.
    wr(3'd1, 32'hA, 4'hF);
    idle(2);
    chk("static_led_a", {28'h0, led_out}, 32'hA);
    idle(5);
    chk("static_led_a_hold", {28'h0, led_out}, 32'hA);
    rd(3'd4, 32'h0000_000A, "status_static");
    wr(3'd0, 32'h0, 4'hF);
    chk("ctrl_off_registered", {28'h0, led_out}, 32'hA);
    idle(1);
    chk("ctrl_off_led", {28'h0, led_out}, 32'h0);

    // PWM duty: LED0 FF, LED1 80, LED2 40, LED3 00.
    wr(3'd2, 32'h0040_80FF, 4'hF);
    wr(3'd1, 32'hF, 4'hF);
    wr(3'd0, 32'h1, 4'hF);
    idle(2);
    fork
      pwm_count(0, 256);
      pwm_count(1, 128);
      pwm_count(2, 64);
      pwm_count(3, 0);
    join
    idle(1);

    // Blink.
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'h1, 4'hF);
    wr(3'd3, 32'd4, 4'hF);
    wr(3'd0, 32'h3, 4'hF);
    idle(2);
    blink_runs(4, 40);
    wr(3'd3, 32'd0, 4'hF);
    idle(2);
    blink_runs(1, 12);
    wr(3'd0, 32'h0, 4'hF);

    // Read/write conflict and reserved addresses.
    avs_address = 3'd1; avs_writedata = 32'h5; avs_byteenable = 4'hF;
    avs_read = 1'b1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
    rd(3'd1, 32'h5, "conflict_write");
    wr(3'd6, 32'hDEAD_BEEF, 4'hF);
    rd(3'd6, 32'h0, "reserved6");
    rd(3'd7, 32'h0, "reserved7");
    rd(3'd5, 32'h1ED0_0001, "id_b2b");
    idle(3);

    // Reset mid-read with LEDs lit.
    wr(3'd1, 32'hF, 4'hF);
    wr(3'd0, 32'h1, 4'hF);
    idle(3);
    chk("pre_reset_led", {28'h0, led_out}, 32'hF);
    avs_address = 3'd5; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_led", {28'h0, led_out}, 32'h0);
    chk("async_rst_rdv", {31'h0, avs_readdatavalid}, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    rd(3'd5, 32'h1ED0_0001, "id_after_reset");
    rd(3'd3, 32'd25_000_000, "period_after_reset");
    rd(3'd0, 32'h0, "ctrl_after_reset");
    idle(3);
    chk("led_after_reset", {28'h0, led_out}, 32'h0);
    chk("sb_drain", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
